// File: rtl/exec_port_arbiter_if.sv
// Request/grant bundle between the issue buffers, the arbiter and the execution unit.
interface exec_port_arbiter_if #(
    parameter int N_REQ    = 4,
    parameter int ROB_SIZE = 32,
    parameter int LAT_W    = 3
);
    localparam int AW = $clog2(ROB_SIZE);
    localparam int IW = $clog2(N_REQ);

    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ-1:0][AW-1:0]    req_rob_addr;
    logic [N_REQ-1:0][LAT_W-1:0] req_lat;
    logic [N_REQ-1:0]            req_retain;
    logic [AW-1:0]               rob_head;
    logic                        restore;
    logic [AW-1:0]               restore_tail;
    logic                        out_stall;
    logic                        grant_valid;
    logic [IW-1:0]               grant_idx;
    logic [AW-1:0]               grant_rob_addr;
    logic                        busy;

    modport slave (
        input  req_valid, req_rob_addr, req_lat, rob_head, restore, restore_tail, out_stall,
        output req_retain, grant_valid, grant_idx, grant_rob_addr, busy
    );

    modport master (
        output req_valid, req_rob_addr, req_lat, rob_head, restore, restore_tail, out_stall,
        input  req_retain, grant_valid, grant_idx, grant_rob_addr, busy
    );
endinterface

// File: rtl/exec_port_arbiter.sv
// Oldest-first arbiter sharing one execution port among N_REQ issue buffers,
// with registered grant, multi-cycle occupancy tracking and mispredict kill.
module exec_port_arbiter #(
    parameter int N_REQ    = 4,
    parameter int ROB_SIZE = 32,
    parameter int LAT_W    = 3
) (
    input logic                 clk,
    input logic                 n_rst,
    exec_port_arbiter_if.slave  bus
);
    localparam int AW = $clog2(ROB_SIZE);
    localparam int IW = $clog2(N_REQ);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                   state, state_next;
    logic [LAT_W-1:0]         busy_cnt, busy_cnt_next;
    logic [AW-1:0]            busy_rob, busy_rob_next;
    logic [N_REQ-1:0][AW-1:0] age;
    logic [N_REQ-1:0]         elig;
    logic                     can_grant;
    logic                     found;
    logic [IW-1:0]            win_idx;
    logic [AW-1:0]            win_age;
    logic [AW-1:0]            win_rob;
    logic [LAT_W-1:0]         win_lat;
    logic                     grant_fire;

    // Window test: offset from head is below the surviving span [head, tail).
    function automatic logic in_win(input logic [AW-1:0] a, input logic [AW-1:0] head,
                                    input logic [AW-1:0] tail);
        logic [AW-1:0] off;
        logic [AW-1:0] span;
        off  = a - head;
        span = tail - head;
        return off < span;
    endfunction

    // Age and eligibility per buffer; flushed entries drop out during a restore.
    always_comb begin
        age  = '0;
        elig = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            age[i]  = bus.req_rob_addr[i] - bus.rob_head;
            elig[i] = bus.req_valid[i] &
                      (~bus.restore | in_win(bus.req_rob_addr[i], bus.rob_head, bus.restore_tail));
        end
    end

    // Oldest eligible buffer wins; strict compare keeps ties at the lowest index.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        win_age = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (elig[i] && (!found || age[i] < win_age)) begin
                found   = 1'b1;
                win_idx = IW'(i);
                win_age = age[i];
            end
        end
        win_rob    = bus.req_rob_addr[win_idx];
        win_lat    = (bus.req_lat[win_idx] == '0) ? LAT_W'(1) : bus.req_lat[win_idx];
        can_grant  = (state == IDLE) && !bus.out_stall;
        grant_fire = can_grant && found;
    end

    // Only the winner releases its entry; everyone retains while in reset.
    always_comb begin
        bus.req_retain = '1;
        if (n_rst && grant_fire) begin
            bus.req_retain[win_idx] = 1'b0;
        end
    end

    // Grant registers: new grant, else restore kill, else clear unless stalled (hold).
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            bus.grant_valid    <= 1'b0;
            bus.grant_idx      <= '0;
            bus.grant_rob_addr <= '0;
        end else if (grant_fire) begin
            bus.grant_valid    <= 1'b1;
            bus.grant_idx      <= win_idx;
            bus.grant_rob_addr <= win_rob;
        end else if (bus.restore &&
                     !in_win(bus.grant_rob_addr, bus.rob_head, bus.restore_tail)) begin
            bus.grant_valid <= 1'b0;
        end else if (!bus.out_stall) begin
            bus.grant_valid <= 1'b0;
        end
    end

    // Occupancy state register.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state    <= IDLE;
            busy_cnt <= '0;
            busy_rob <= '0;
        end else begin
            state    <= state_next;
            busy_cnt <= busy_cnt_next;
            busy_rob <= busy_rob_next;
        end
    end

    // Occupancy next-state: count down L-1 busy cycles, or free early on a kill.
    always_comb begin
        state_next    = state;
        busy_cnt_next = busy_cnt;
        busy_rob_next = busy_rob;
        case (state)
            IDLE: begin
                if (grant_fire && win_lat > LAT_W'(1)) begin
                    state_next    = BUSY;
                    busy_cnt_next = win_lat - LAT_W'(1);
                    busy_rob_next = win_rob;
                end
            end
            BUSY: begin
                if (bus.restore && !in_win(busy_rob, bus.rob_head, bus.restore_tail)) begin
                    state_next    = IDLE;
                    busy_cnt_next = '0;
                end else if (busy_cnt == LAT_W'(1)) begin
                    state_next    = IDLE;
                    busy_cnt_next = '0;
                end else begin
                    busy_cnt_next = busy_cnt - LAT_W'(1);
                end
            end
        endcase
    end

    assign bus.busy = (state == BUSY);
endmodule

// File: tb/tb_exec_port_arbiter.sv
// Scoreboard bench for exec_port_arbiter: directed scenarios plus random traffic.
module tb_exec_port_arbiter;
    localparam int N_REQ    = 4;
    localparam int ROB_SIZE = 32;
    localparam int LAT_W    = 3;
    localparam int AW       = 5;
    localparam int IW       = 2;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    exec_port_arbiter_if #(.N_REQ(N_REQ), .ROB_SIZE(ROB_SIZE), .LAT_W(LAT_W)) bus ();

    exec_port_arbiter #(.N_REQ(N_REQ), .ROB_SIZE(ROB_SIZE), .LAT_W(LAT_W)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    typedef struct {
        logic          gv;
        logic [IW-1:0] idx;
        logic [AW-1:0] rob;
        logic          busy;
    } exp_t;

    exp_t             sb[$];
    logic             m_gv = 1'b0;
    logic [IW-1:0]    m_idx = '0;
    logic [AW-1:0]    m_rob = '0;
    logic             m_busy = 1'b0;
    int               m_cnt = 0;
    logic [AW-1:0]    m_brob = '0;
    logic [N_REQ-1:0] last_retain;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic mw(input logic [AW-1:0] a);
        logic [AW-1:0] o;
        logic [AW-1:0] s;
        o = a - bus.rob_head;
        s = bus.restore_tail - bus.rob_head;
        return o < s;
    endfunction

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] r,
                           input logic [LAT_W-1:0] l);
        bus.req_valid[i]    = v;
        bus.req_rob_addr[i] = r;
        bus.req_lat[i]      = l;
    endtask

    task automatic clear_reqs();
        bus.req_valid    = '0;
        bus.req_rob_addr = '0;
        bus.req_lat      = '0;
    endtask

    // One cycle: check retain before the edge, predict and queue the registered result, compare after.
    task automatic tick(input string tag);
        exp_t             e;
        int               w;
        int               l;
        logic             can;
        logic [N_REQ-1:0] er;
        logic [AW-1:0]    ag;
        #3;
        can = !m_busy && !bus.out_stall;
        w   = -1;
        for (int a = 0; a < ROB_SIZE; a++) begin
            for (int i = 0; i < N_REQ; i++) begin
                ag = bus.req_rob_addr[i] - bus.rob_head;
                if (w < 0 && bus.req_valid[i] && (!bus.restore || mw(bus.req_rob_addr[i])) && ag == a)
                    w = i;
            end
        end
        er = '1;
        if (n_rst && can && w >= 0) er[w] = 1'b0;
        last_retain = bus.req_retain;
        check({tag, "_retain"}, bus.req_retain, er);
        if (!n_rst) begin
            m_gv = 0; m_idx = '0; m_rob = '0; m_busy = 0; m_cnt = 0; m_brob = '0;
        end else begin
            if (m_busy) begin
                if (bus.restore && !mw(m_brob)) begin m_busy = 0; m_cnt = 0; end
                else if (m_cnt == 1) begin m_busy = 0; m_cnt = 0; end
                else m_cnt--;
            end
            if (can && w >= 0) begin
                m_gv  = 1;
                m_idx = IW'(w);
                m_rob = bus.req_rob_addr[w];
                l = (bus.req_lat[w] == 0) ? 1 : int'(bus.req_lat[w]);
                if (l > 1) begin m_busy = 1; m_cnt = l - 1; m_brob = m_rob; end
            end else if (bus.restore && !mw(m_rob)) begin
                m_gv = 0;
            end else if (!bus.out_stall) begin
                m_gv = 0;
            end
        end
        e = '{m_gv, m_idx, m_rob, m_busy};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, "_gv"}, bus.grant_valid, e.gv);
        check({tag, "_idx"}, bus.grant_idx, e.idx);
        check({tag, "_rob"}, bus.grant_rob_addr, e.rob);
        check({tag, "_busy"}, bus.busy, e.busy);
    endtask

    initial begin
        clear_reqs();
        bus.rob_head = '0; bus.restore = 0; bus.restore_tail = '0; bus.out_stall = 0;
        @(posedge clk); #1;
        tick("rst0");
        tick("rst1");
        check("rst_retain", last_retain, 4'hF);
        check("rst_gv", bus.grant_valid, 0);
        n_rst = 1;

        // Oldest of two by age
        bus.rob_head = 2; set_req(0, 1, 5, 1); set_req(1, 1, 3, 1);
        tick("t1");
        check("t1_ret", last_retain, 4'b1101);
        check("t1_idx", bus.grant_idx, 1);
        check("t1_rob", bus.grant_rob_addr, 3);

        // Age wraps around the ROB
        clear_reqs(); bus.rob_head = 30; set_req(0, 1, 1, 1); set_req(1, 1, 31, 1);
        tick("t2a");
        check("t2a_idx", bus.grant_idx, 1);
        check("t2a_rob", bus.grant_rob_addr, 31);
        set_req(1, 0, 31, 1);
        tick("t2b");
        check("t2b_idx", bus.grant_idx, 0);
        check("t2b_rob", bus.grant_rob_addr, 1);

        // Three-cycle occupancy
        clear_reqs(); bus.rob_head = 2; set_req(2, 1, 4, 3);
        tick("t3a");
        check("t3a_idx", bus.grant_idx, 2);
        check("t3a_busy", bus.busy, 1);
        set_req(2, 1, 5, 3);
        tick("t3b");
        check("t3b_ret", last_retain, 4'hF);
        check("t3b_busy", bus.busy, 1);
        tick("t3c");
        check("t3c_ret", last_retain, 4'hF);
        check("t3c_busy", bus.busy, 0);
        set_req(2, 1, 5, 1);
        tick("t3d");
        check("t3d_ret", last_retain, 4'b1011);
        check("t3d_gv", bus.grant_valid, 1);

        // Restore window filters requests
        clear_reqs(); bus.rob_head = 2; bus.restore = 1; bus.restore_tail = 6;
        set_req(0, 1, 9, 1); set_req(1, 1, 4, 1);
        tick("t4a");
        check("t4a_rob", bus.grant_rob_addr, 4);
        set_req(1, 0, 4, 1);
        tick("t4b");
        check("t4b_gv", bus.grant_valid, 0);
        bus.restore = 0;

        // Stall holds the grant, restore kills it anyway
        clear_reqs(); set_req(0, 1, 9, 1);
        tick("t5a");
        check("t5a_rob", bus.grant_rob_addr, 9);
        bus.out_stall = 1;
        for (int k = 0; k < 3; k++) begin
            tick("t5s");
            check("t5s_gv", bus.grant_valid, 1);
            check("t5s_ret", last_retain, 4'hF);
        end
        bus.restore = 1; bus.restore_tail = 6;
        tick("t5k");
        check("t5k_gv", bus.grant_valid, 0);
        bus.restore = 0; bus.out_stall = 0;

        // Reset while busy
        clear_reqs(); set_req(3, 1, 10, 6);
        tick("t6a");
        check("t6a_busy", bus.busy, 1);
        n_rst = 0; clear_reqs();
        tick("t6r");
        check("t6r_busy", bus.busy, 0);
        check("t6r_gv", bus.grant_valid, 0);
        n_rst = 1; set_req(0, 1, 3, 1);
        tick("t6b");
        check("t6b_gv", bus.grant_valid, 1);
        check("t6b_idx", bus.grant_idx, 0);

        // Random traffic against the reference model
        for (int c = 0; c < 400; c++) begin
            bus.rob_head     = AW'($urandom);
            bus.restore_tail = AW'($urandom);
            bus.restore      = ($urandom_range(0, 9) == 0);
            bus.out_stall    = ($urandom_range(0, 4) == 0);
            n_rst            = ($urandom_range(0, 99) != 0);
            for (int i = 0; i < N_REQ; i++)
                set_req(i, ($urandom_range(0, 2) != 0), AW'($urandom), LAT_W'($urandom));
            tick("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
